// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a single-cycle-latency word RAM.
// Optional macro MAU_MISALIGN_CHECK_EN turns misaligned halfword/word accesses into errors.
module mem_access_unit #(
  parameter int unsigned RAM_SIZE = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_enable,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // state    | meaning
  // IDLE     | ready for a request
  // RD_ISSUE | RAM read strobe (load, or first half of sub-word store)
  // RD_WAIT  | RAM data returns; extend for load or merge for store
  // WR_ISSUE | RAM write strobe
  // RSP      | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RSP} state_t;

  state_t      state, state_n;
  logic        wr_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, data_q;
  logic        accept, req_err;
  logic [4:0]  lane_shift;
  logic [31:0] lane_data, lane_mask, load_ext, merged;

  assign accept = req_valid && (state == IDLE);

  always_comb begin
    req_err = ({1'b0, req_addr} >= 33'(RAM_SIZE));
`ifdef MAU_MISALIGN_CHECK_EN
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size[1] && req_addr[1:0] != 2'b00) req_err = 1'b1;
`else
    // Misaligned low bits are simply ignored by the lane selection below.
`endif
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) state_n = RSP;
          else if (req_write && req_size[1]) state_n = WR_ISSUE;
          else state_n = RD_ISSUE;
        end
      end
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT:  state_n = wr_q ? WR_ISSUE : RSP;
      WR_ISSUE: state_n = RSP;
      RSP:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  // Little-endian lane: byte at addr[1:0], halfword at addr[1].
  always_comb begin
    lane_shift = 5'd0;
    lane_mask  = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        lane_shift = {addr_q[1:0], 3'b000};
        lane_mask  = 32'h0000_00FF << lane_shift;
      end
      2'b01: begin
        lane_shift = {addr_q[1], 4'b0000};
        lane_mask  = 32'h0000_FFFF << lane_shift;
      end
      default: ;
    endcase
    lane_data = mem_rdata >> lane_shift;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_ext = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
      default: load_ext = mem_rdata;
    endcase
    merged = (mem_rdata & ~lane_mask) | ((data_q << lane_shift) & lane_mask);
  end

  // data_q holds store data, then the merged word (store) or extended result (load).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      uns_q  <= 1'b0;
      err_q  <= 1'b0;
      size_q <= 2'b00;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else if (accept) begin
      wr_q   <= req_write;
      uns_q  <= req_unsigned;
      err_q  <= req_err;
      size_q <= req_size;
      addr_q <= req_addr;
      data_q <= req_wdata;
    end else if (state == RD_WAIT) begin
      data_q <= wr_q ? merged : load_ext;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RSP) && !rst;
  assign resp_error = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !wr_q && !err_q) ? data_q : 32'd0;

  // Strobes are killed by rst directly so an interrupted read-modify-write never writes.
  assign mem_enable = !rst && (state == RD_ISSUE || state == WR_ISSUE);
  assign mem_write  = !rst && (state == WR_ISSUE);
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 32 KiB word RAM.
// Misalignment expectations follow MAU_MISALIGN_CHECK_EN when it is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error, mem_enable, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int rsp_cnt = 0;

  logic [15:0] en_mask, wr_mask;
  logic [31:0] rsp_cyc, rdata_o, waddr, wdat;
  logic        err_o;
  int          wc0, rc0;

  logic [31:0] ram [0:8191];

  mem_access_unit #(.RAM_SIZE(32768)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_write) ram[mem_addr[14:2]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[14:2]];
    end
    if (mem_enable && mem_write) wr_cnt <= wr_cnt + 1;
    if (resp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request in the current (IDLE) cycle T and traces cycles T..T+10.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    en_mask = '0; wr_mask = '0; rsp_cyc = 0; rdata_o = 0; err_o = 0; waddr = 0; wdat = 0;
    #1;
    check("ready_at_T", {31'd0, req_ready}, 32'd1);
    en_mask[0] = mem_enable;
    for (int i = 1; i <= 10 && rsp_cyc == 0; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      en_mask[i] = mem_enable;
      if (mem_enable && mem_write) begin
        wr_mask[i] = 1'b1; waddr = mem_addr; wdat = mem_wdata;
      end
      if (resp_valid) begin
        rsp_cyc = i; rdata_o = resp_rdata; err_o = resp_error;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] exp);
    run_req(1'b0, sz, u, a, 32'h0);
    check(tag, rdata_o, exp);
    check({tag, "_rsp"}, rsp_cyc, 32'd3);
    check({tag, "_en"}, {16'd0, en_mask}, 32'h2);
    check({tag, "_err"}, {31'd0, err_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_en", {31'd0, mem_enable}, 32'd0);

    // Word store to seed 0x100.
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF7F01);
    check("wst_en", {16'd0, en_mask}, 32'h2);
    check("wst_wr", {16'd0, wr_mask}, 32'h2);
    check("wst_rsp", rsp_cyc, 32'd2);
    check("wst_addr", waddr, 32'h100);
    check("wst_data", wdat, 32'h80FF7F01);
    check("wst_rdata", rdata_o, 32'd0);

    load_chk("lb_101_s", 2'b00, 1'b0, 32'h101, 32'h0000007F);
    load_chk("lb_102_s", 2'b00, 1'b0, 32'h102, 32'hFFFFFFFF);
    load_chk("lb_102_u", 2'b00, 1'b1, 32'h102, 32'h000000FF);
    load_chk("lh_102_s", 2'b01, 1'b0, 32'h102, 32'hFFFF80FF);
    load_chk("lh_102_u", 2'b01, 1'b1, 32'h102, 32'h000080FF);
    load_chk("lh_100_s", 2'b01, 1'b0, 32'h100, 32'h00007F01);
    load_chk("lw_100", 2'b10, 1'b0, 32'h100, 32'h80FF7F01);
    load_chk("lw_sz11", 2'b11, 1'b0, 32'h100, 32'h80FF7F01);

    run_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
`ifdef MAU_MISALIGN_CHECK_EN
    check("lh_101_err", {31'd0, err_o}, 32'd1);
    check("lh_101_rsp", rsp_cyc, 32'd1);
    check("lh_101_en", {16'd0, en_mask}, 32'h0);
    check("lh_101_data", rdata_o, 32'd0);
`else
    check("lh_101_err", {31'd0, err_o}, 32'd0);
    check("lh_101_rsp", rsp_cyc, 32'd3);
    check("lh_101_data", rdata_o, 32'h00007F01);
`endif
    run_req(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
`ifdef MAU_MISALIGN_CHECK_EN
    check("lw_103_err", {31'd0, err_o}, 32'd1);
    check("lw_103_data", rdata_o, 32'd0);
`else
    check("lw_103_err", {31'd0, err_o}, 32'd0);
    check("lw_103_data", rdata_o, 32'h80FF7F01);
`endif

    // Byte store: read-modify-write touching only lane 1.
    run_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h123456AB);
    check("sb_en", {16'd0, en_mask}, 32'hA);
    check("sb_wr", {16'd0, wr_mask}, 32'h8);
    check("sb_rsp", rsp_cyc, 32'd4);
    check("sb_addr", waddr, 32'h100);
    check("sb_data", wdat, 32'h80FFAB01);
    check("sb_rdata", rdata_o, 32'd0);

    run_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000BEEF);
    check("sh_wr", {16'd0, wr_mask}, 32'h8);
    check("sh_data", wdat, 32'hBEEFAB01);
    load_chk("lw_after_sh", 2'b10, 1'b0, 32'h100, 32'hBEEFAB01);

    run_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
    check("sw200_wr", {16'd0, wr_mask}, 32'h2);
    check("sw200_rsp", rsp_cyc, 32'd2);
    load_chk("lw_200", 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);

    run_req(1'b1, 2'b11, 1'b0, 32'h300, 32'h12345678);
    check("sw11_wr", {16'd0, wr_mask}, 32'h2);
    load_chk("lw_300", 2'b10, 1'b0, 32'h300, 32'h12345678);

    // Out-of-range accesses.
    run_req(1'b0, 2'b10, 1'b0, 32'h8000, 32'h0);
    check("oor_err", {31'd0, err_o}, 32'd1);
    check("oor_rsp", rsp_cyc, 32'd1);
    check("oor_en", {16'd0, en_mask}, 32'h0);
    check("oor_rdata", rdata_o, 32'd0);
    run_req(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h55);
    check("oor_st_err", {31'd0, err_o}, 32'd1);
    check("oor_st_en", {16'd0, en_mask}, 32'h0);
    run_req(1'b0, 2'b10, 1'b0, 32'h7FFC, 32'h0);
    check("top_word_err", {31'd0, err_o}, 32'd0);
    check("top_word_rsp", rsp_cyc, 32'd3);

    // Reset during RD_WAIT of a byte store.
    wc0 = wr_cnt; rc0 = rsp_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h100; req_wdata = 32'h55;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rstmid_en", {31'd0, mem_enable}, 32'd0);
    check("rstmid_wr", {31'd0, mem_write}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_resp", {31'd0, resp_valid}, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    check("rstmid_wr_cnt", wr_cnt - wc0, 32'd0);
    check("rstmid_rsp_cnt", rsp_cnt - rc0, 32'd0);
    load_chk("rstmid_word", 2'b10, 1'b0, 32'h100, 32'hBEEFAB01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32768, the byte size of the attached RAM; addresses >= RAM_SIZE are out of range.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, CPU access request present.
REQ-005 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1, 1 means store and 0 means load.
REQ-007 SHALL have port req_size, input, 2, 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-008 SHALL have port req_unsigned, input, 1, zero-extend sub-word loads.
REQ-009 SHALL have ports req_addr and req_wdata, input, 32 each, byte address and store data (LSB-aligned).
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-012 SHALL have port resp_error, output, 1, access rejected, qualified by resp_valid.
REQ-013 SHALL have ports mem_enable and mem_write, output, 1 each, RAM strobe and write select.
REQ-014 SHALL have ports mem_addr and mem_wdata, output, 32 each; mem_addr is word-aligned ({addr[31:2],2'b00}).
REQ-015 SHALL have port mem_rdata, input, 32; valid the cycle after a cycle with mem_enable=1 and mem_write=0.

Function
REQ-016 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RSP; req_ready=1 only in IDLE.
REQ-017 SHALL accept on req_valid&&req_ready at cycle T and latch all req_* fields; req_* are ignored outside IDLE.
REQ-018 Load SHALL be IDLE -> RD_ISSUE (T+1, mem_enable=1, mem_write=0) -> RD_WAIT (T+2, sample mem_rdata) -> RSP (T+3, resp_valid=1) -> IDLE.
REQ-019 Word store SHALL be IDLE -> WR_ISSUE (T+1, mem_enable=1, mem_write=1, mem_wdata=req_wdata) -> RSP (T+2).
REQ-020 Byte/halfword store SHALL read-modify-write: RD_ISSUE (T+1) -> RD_WAIT (T+2, merge) -> WR_ISSUE (T+3) -> RSP (T+4); only the addressed lanes change.
REQ-021 Lane selection SHALL be little-endian: byte lane addr[1:0], halfword lane addr[1]*16.
REQ-022 Sub-word loads SHALL sign-extend unless req_unsigned=1; word loads pass unmodified.
REQ-023 mem_* outputs SHALL depend only on state and latched registers, with no combinational path from req_*; mem_enable=0 in IDLE, RD_WAIT and RSP.
REQ-024 An out-of-range access SHALL go IDLE -> RSP at T+1 with resp_error=1, resp_rdata=0, and no mem_enable.
REQ-025 resp_valid SHALL be high exactly one cycle per accepted request; a new request is accepted the cycle after RSP at the earliest.

Reset
REQ-026 Reset SHALL set state IDLE, resp_valid=0, resp_error=0, resp_rdata=0, all latched registers 0; req_ready=1 after the reset edge.
REQ-027 mem_enable and mem_write SHALL be forced 0 combinationally while rst=1, so an interrupted RMW never writes.
REQ-028 Reset mid-operation SHALL abort the access with no resp_valid pulse.

Configuration
REQ-029 Macro MAU_MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL take the error path of REQ-024.
REQ-030 Macro undefined: misaligned low address bits SHALL be ignored (halfword uses addr[1], word uses the whole word); resp_error is raised only for out-of-range accesses.

Verification
REQ-031 Word 0x100=0x80FF7F01; byte loads at 0x101 signed, 0x102 signed, 0x102 unsigned -> resp_rdata 0x0000007F, 0xFFFFFFFF, 0x000000FF.
REQ-032 Same word; signed halfword load at 0x102 -> 0xFFFF80FF; accept at T, mem_enable at T+1 only, resp_valid at T+3.
REQ-033 Store byte 0xAB at 0x101 -> RD_ISSUE at T+1, write at T+3 with mem_addr=0x100 and mem_wdata=0x80FFAB01, resp_valid at T+4.
REQ-034 Word store 0xDEADBEEF at 0x200 -> one write cycle at T+1, resp at T+2, then a load at 0x200 returns 0xDEADBEEF.
REQ-035 Load at 0x8000 with RAM_SIZE=32768 -> resp_error=1 at T+1 with no mem_enable; with the macro, halfword load at 0x101 gives the same result, and without it returns the halfword at 0x100.
REQ-036 rst=1 during RD_WAIT of a byte store -> no mem_write cycle, no resp_valid, word unchanged, req_ready=1 after reset.
